// File: rtl/cpu_sram_axi_bridge.sv
// Bridges the core's SRAM-style inst/data ports onto a single 32-bit AXI master, one transaction in flight.
// Optional BRIDGE_PERF_CNT_EN adds read/write/stall performance counters.
module cpu_sram_axi_bridge #(
  parameter logic [3:0] INST_ID   = 4'd0,
  parameter logic [3:0] DATA_ID   = 4'd1,
  parameter int         TIMEOUT_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic [31:0] inst_rdata,
  output logic        inst_data_ok,
  input  logic        data_req,
  input  logic [3:0]  data_wen,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_data_ok,
  output logic        core_stall,
  output logic [31:0] araddr,
  output logic [3:0]  arid,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic [3:0]  rid,
  input  logic [1:0]  rresp,
  input  logic        rvalid,
  output logic        rready,
  output logic [31:0] awaddr,
  output logic [3:0]  awid,
  output logic [7:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready,
  output logic        bus_err
`ifdef BRIDGE_PERF_CNT_EN
  ,
  output logic [31:0] perf_rd_cnt,
  output logic [31:0] perf_wr_cnt,
  output logic [31:0] perf_stall_cnt
`endif
);

  typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_AW_W, S_B} state_e;

  state_e                 state_q, state_d;
  logic [31:0]            addr_q, addr_d;
  logic [3:0]             wen_q, wen_d;
  logic [31:0]            wdata_q, wdata_d;
  logic [3:0]             id_q, id_d;
  logic                   is_data_q, is_data_d;
  logic                   aw_done_q, aw_done_d;
  logic                   w_done_q, w_done_d;
  logic [TIMEOUT_W-1:0]   wdog_q, wdog_d, wdog_inc;
  logic                   inst_ok_q, inst_ok_d;
  logic                   data_ok_q, data_ok_d;
  logic [31:0]            inst_rdata_q, inst_rdata_d;
  logic [31:0]            data_rdata_q, data_rdata_d;
  logic                   bus_err_q, bus_err_d;

  assign wdog_inc = wdog_q + TIMEOUT_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      wen_q        <= '0;
      wdata_q      <= '0;
      id_q         <= '0;
      is_data_q    <= 1'b0;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
      wdog_q       <= '0;
      inst_ok_q    <= 1'b0;
      data_ok_q    <= 1'b0;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
      bus_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wen_q        <= wen_d;
      wdata_q      <= wdata_d;
      id_q         <= id_d;
      is_data_q    <= is_data_d;
      aw_done_q    <= aw_done_d;
      w_done_q     <= w_done_d;
      wdog_q       <= wdog_d;
      inst_ok_q    <= inst_ok_d;
      data_ok_q    <= data_ok_d;
      inst_rdata_q <= inst_rdata_d;
      data_rdata_q <= data_rdata_d;
      bus_err_q    <= bus_err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wen_d        = wen_q;
    wdata_d      = wdata_q;
    id_d         = id_q;
    is_data_d    = is_data_q;
    aw_done_d    = aw_done_q;
    w_done_d     = w_done_q;
    wdog_d       = '0;
    inst_ok_d    = 1'b0;
    data_ok_d    = 1'b0;
    inst_rdata_d = inst_rdata_q;
    data_rdata_d = data_rdata_q;
    bus_err_d    = bus_err_q;
    case (state_q)
      S_IDLE: begin
        // The core still holds req during its data_ok cycle; don't mistake it for a new request.
        if (!(inst_ok_q || data_ok_q)) begin
          if (data_req) begin
            addr_d    = data_addr;
            wen_d     = data_wen;
            wdata_d   = data_wdata;
            id_d      = DATA_ID;
            is_data_d = 1'b1;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
            state_d   = (data_wen != 4'd0) ? S_AW_W : S_AR;
          end else if (inst_req) begin
            addr_d    = inst_addr;
            wen_d     = '0;
            wdata_d   = '0;
            id_d      = INST_ID;
            is_data_d = 1'b0;
            state_d   = S_AR;
          end
        end
      end
      S_AR: if (arready) state_d = S_R;
      S_R: begin
        wdog_d = wdog_inc;
        if (rvalid) begin
          if (is_data_q) begin
            data_rdata_d = rdata;
            data_ok_d    = 1'b1;
          end else begin
            inst_rdata_d = rdata;
            inst_ok_d    = 1'b1;
          end
          if (rresp != 2'b00 || rid != id_q) bus_err_d = 1'b1;
          state_d = S_IDLE;
        end else if (&wdog_inc) begin
          if (is_data_q) begin
            data_rdata_d = '0;
            data_ok_d    = 1'b1;
          end else begin
            inst_rdata_d = '0;
            inst_ok_d    = 1'b1;
          end
          bus_err_d = 1'b1;
          state_d   = S_IDLE;
        end
      end
      S_AW_W: begin
        aw_done_d = aw_done_q | awready;
        w_done_d  = w_done_q | wready;
        if (aw_done_d && w_done_d) state_d = S_B;
      end
      S_B: begin
        wdog_d = wdog_inc;
        if (bvalid) begin
          data_ok_d = 1'b1;
          if (bresp != 2'b00 || bid != DATA_ID) bus_err_d = 1'b1;
          state_d = S_IDLE;
        end else if (&wdog_inc) begin
          data_ok_d = 1'b1;
          bus_err_d = 1'b1;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (state_d != state_q) wdog_d = '0;
  end

  // Valids decode straight from the async-reset state so they drop the moment rst rises.
  assign arvalid = (state_q == S_AR);
  assign rready  = (state_q == S_R);
  assign awvalid = (state_q == S_AW_W) && !aw_done_q;
  assign wvalid  = (state_q == S_AW_W) && !w_done_q;
  assign bready  = (state_q == S_B);

  assign araddr  = addr_q;
  assign arid    = id_q;
  assign arlen   = 8'd0;
  assign arsize  = 3'd2;
  assign arburst = 2'b01;
  assign awaddr  = addr_q;
  assign awid    = DATA_ID;
  assign awlen   = 8'd0;
  assign awsize  = 3'd2;
  assign awburst = 2'b01;
  assign wdata   = wdata_q;
  assign wstrb   = wen_q;
  assign wlast   = 1'b1;

  assign inst_rdata   = inst_rdata_q;
  assign inst_data_ok = inst_ok_q;
  assign data_rdata   = data_rdata_q;
  assign data_data_ok = data_ok_q;
  assign bus_err      = bus_err_q;
  assign core_stall   = (inst_req | data_req) & ~(inst_ok_q | data_ok_q);

`ifdef BRIDGE_PERF_CNT_EN
  logic [31:0] rd_cnt_q, wr_cnt_q, stall_cnt_q;

  // wen_q still describes the finished transaction during its data_ok cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_cnt_q    <= '0;
      wr_cnt_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (inst_ok_q || (data_ok_q && wen_q == 4'd0)) rd_cnt_q <= rd_cnt_q + 32'd1;
      if (data_ok_q && wen_q != 4'd0) wr_cnt_q <= wr_cnt_q + 32'd1;
      if (core_stall) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign perf_rd_cnt    = rd_cnt_q;
  assign perf_wr_cnt    = wr_cnt_q;
  assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_cpu_sram_axi_bridge.sv
// Scoreboard bench: stimulus pushes expected completions and AXI beats; monitors and a slave model check them.
module tb_cpu_sram_axi_bridge;
  localparam logic [3:0] INST_ID = 4'd0;
  localparam logic [3:0] DATA_ID = 4'd1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        inst_req = 1'b0, data_req = 1'b0;
  logic [31:0] inst_addr = '0, data_addr = '0, data_wdata = '0;
  logic [3:0]  data_wen = '0;
  logic [31:0] inst_rdata, data_rdata;
  logic        inst_data_ok, data_data_ok, core_stall, bus_err;
  logic [31:0] araddr, awaddr, wdata;
  logic [3:0]  arid, awid, wstrb;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize;
  logic [1:0]  arburst, awburst;
  logic        arvalid, rready, awvalid, wvalid, wlast, bready;
  logic        arready, rvalid, awready, wready, bvalid;
  logic [31:0] rdata;
  logic [3:0]  rid, bid;
  logic [1:0]  rresp, bresp;
`ifdef BRIDGE_PERF_CNT_EN
  logic [31:0] perf_rd_cnt, perf_wr_cnt, perf_stall_cnt;
`endif

  cpu_sram_axi_bridge #(.INST_ID(INST_ID), .DATA_ID(DATA_ID), .TIMEOUT_W(4)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdata(inst_rdata), .inst_data_ok(inst_data_ok),
    .data_req(data_req), .data_wen(data_wen), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_rdata(data_rdata), .data_data_ok(data_data_ok), .core_stall(core_stall),
    .araddr(araddr), .arid(arid), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rid(rid), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awid(awid), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .bus_err(bus_err)
`ifdef BRIDGE_PERF_CNT_EN
    , .perf_rd_cnt(perf_rd_cnt), .perf_wr_cnt(perf_wr_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int compared = 0, mismatched = 0;
  int cyc = 0;
  int last_dok_cyc = 0, b_cyc = 0;
  bit chk_order = 1'b0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [31:0] rd; bit chk_rd; bit err; } ok_exp_t;
  typedef struct { logic [3:0] id; logic [31:0] addr; logic [31:0] rd; logic [1:0] resp;
                   bit bad_id; bit never; int rdly; } ar_exp_t;
  typedef struct { logic [31:0] addr; logic [31:0] wd; logic [3:0] strb;
                   int aw_dly; int w_dly; int b_dly; logic [1:0] resp; } w_exp_t;
  ok_exp_t inst_q[$], data_q[$];
  ar_exp_t ar_q[$];
  w_exp_t  w_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Completion monitor
  ok_exp_t mi, md;
  always @(negedge clk) begin
    if (!rst) begin
      if (inst_data_ok) begin
        if (inst_q.size() == 0) chk("inst_ok_unexpected", 32'd1, 32'd0);
        else begin
          mi = inst_q.pop_front();
          if (mi.chk_rd) chk("inst_rdata", inst_rdata, mi.rd);
          chk("inst_bus_err", 32'(bus_err), 32'(mi.err));
        end
      end
      if (data_data_ok) begin
        last_dok_cyc = cyc;
        if (data_q.size() == 0) chk("data_ok_unexpected", 32'd1, 32'd0);
        else begin
          md = data_q.pop_front();
          if (md.chk_rd) chk("data_rdata", data_rdata, md.rd);
          chk("data_bus_err", 32'(bus_err), 32'(md.err));
        end
      end
    end
  end

  // AXI read slave
  ar_exp_t ae;
  initial begin
    arready = 1'b0; rvalid = 1'b0; rdata = '0; rid = '0; rresp = '0;
    forever begin
      @(posedge clk); #1;
      if (!rst && arvalid) begin
        if (ar_q.size() == 0) chk("ar_unexpected", 32'd1, 32'd0);
        else begin
          ae = ar_q.pop_front();
          chk("arid", 32'(arid), 32'(ae.id));
          chk("araddr", araddr, ae.addr);
          if (chk_order && arid == INST_ID) chk("inst_ar_after_data_ok", 32'(cyc > last_dok_cyc), 32'd1);
          arready = 1'b1;
          @(posedge clk); #1;
          arready = 1'b0;
          if (!ae.never) begin
            repeat (ae.rdly) begin @(posedge clk); #1; end
            rvalid = 1'b1; rdata = ae.rd; rresp = ae.resp;
            rid = ae.bad_id ? (ae.id ^ 4'hF) : ae.id;
            @(posedge clk); #1;
            rvalid = 1'b0;
          end
        end
      end
    end
  end

  // AXI write slave: AW and W accepted on independent delays
  w_exp_t we;
  int c;
  bit awd, wd;
  initial begin
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bid = '0; bresp = '0;
    forever begin
      @(posedge clk); #1;
      if (!rst && (awvalid || wvalid)) begin
        if (w_q.size() == 0) chk("aw_unexpected", 32'd1, 32'd0);
        else begin
          we = w_q.pop_front();
          c = 0; awd = 1'b0; wd = 1'b0;
          while (!(awd && wd) && !rst) begin
            chk("awvalid_level", 32'(awvalid), 32'(!awd));
            chk("wvalid_level", 32'(wvalid), 32'(!wd));
            awready = !awd && (c >= we.aw_dly);
            wready  = !wd && (c >= we.w_dly);
            if (awready) begin
              chk("awaddr", awaddr, we.addr);
              chk("awid", 32'(awid), 32'(DATA_ID));
            end
            if (wready) begin
              chk("wdata", wdata, we.wd);
              chk("wstrb", 32'(wstrb), 32'(we.strb));
              chk("wlast", 32'(wlast), 32'd1);
            end
            @(posedge clk); #1;
            if (awready) awd = 1'b1;
            if (wready) wd = 1'b1;
            awready = 1'b0; wready = 1'b0;
            c++;
          end
          if (!rst) begin
            repeat (we.b_dly) begin @(posedge clk); #1; end
            bvalid = 1'b1; bid = DATA_ID; bresp = we.resp; b_cyc = cyc;
            @(posedge clk); #1;
            bvalid = 1'b0;
          end
        end
      end
    end
  end

  task automatic wait_ok(input bit d, output int n);
    n = 0;
    do begin
      @(negedge clk); n++;
    end while (!(d ? data_data_ok : inst_data_ok) && n < 200);
    if (!(d ? data_data_ok : inst_data_ok)) chk(d ? "data_ok_timeout" : "inst_ok_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic do_inst(input logic [31:0] a, output int n);
    inst_req = 1'b1; inst_addr = a;
    wait_ok(1'b0, n);
    inst_req = 1'b0;
  endtask

  task automatic do_data(input logic [3:0] wen, input logic [31:0] a, input logic [31:0] wd_in, output int n);
    data_req = 1'b1; data_wen = wen; data_addr = a; data_wdata = wd_in;
    wait_ok(1'b1, n);
    data_req = 1'b0; data_wen = '0;
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_arvalid"}, 32'(arvalid), 32'd0);
    chk({tag, "_awvalid"}, 32'(awvalid), 32'd0);
    chk({tag, "_wvalid"}, 32'(wvalid), 32'd0);
    chk({tag, "_rready"}, 32'(rready), 32'd0);
    chk({tag, "_bready"}, 32'(bready), 32'd0);
    chk({tag, "_inst_ok"}, 32'(inst_data_ok), 32'd0);
    chk({tag, "_data_ok"}, 32'(data_data_ok), 32'd0);
    chk({tag, "_bus_err"}, 32'(bus_err), 32'd0);
    chk({tag, "_inst_rdata"}, inst_rdata, 32'd0);
    chk({tag, "_data_rdata"}, data_rdata, 32'd0);
`ifdef BRIDGE_PERF_CNT_EN
    chk({tag, "_perf_rd"}, perf_rd_cnt, 32'd0);
    chk({tag, "_perf_wr"}, perf_wr_cnt, 32'd0);
    chk({tag, "_perf_stall"}, perf_stall_cnt, 32'd0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int n1, n2;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    chk("arsize", 32'(arsize), 32'd2);
    chk("arlen", 32'(arlen), 32'd0);
    chk("arburst", 32'(arburst), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Fetch: arready immediately, rvalid one cycle after the AR handshake
    ar_q.push_back('{INST_ID, 32'hBFC0_0000, 32'h3C08_8000, 2'b00, 1'b0, 1'b0, 1});
    inst_q.push_back('{32'h3C08_8000, 1'b1, 1'b0});
    inst_req = 1'b1; inst_addr = 32'hBFC0_0000;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t1_stall", 32'(core_stall), 32'(i < 4));
      chk("t1_inst_ok", 32'(inst_data_ok), 32'(i == 4));
    end
    @(posedge clk); #1;
    inst_req = 1'b0;
    repeat (2) @(posedge clk); #1;

    // Simultaneous inst and data read: data goes first
    chk_order = 1'b1;
    ar_q.push_back('{DATA_ID, 32'h8000_0010, 32'h1234_5678, 2'b00, 1'b0, 1'b0, 0});
    ar_q.push_back('{INST_ID, 32'hBFC0_0004, 32'h2402_0001, 2'b00, 1'b0, 1'b0, 2});
    data_q.push_back('{32'h1234_5678, 1'b1, 1'b0});
    inst_q.push_back('{32'h2402_0001, 1'b1, 1'b0});
    fork
      do_data(4'b0000, 32'h8000_0010, 32'h0, n1);
      do_inst(32'hBFC0_0004, n2);
    join
    chk_order = 1'b0;
    repeat (2) @(posedge clk); #1;

    // Store with awready two cycles ahead of wready
    w_q.push_back('{32'h8000_0020, 32'h0000_BEEF, 4'b0011, 0, 2, 0, 2'b00});
    data_q.push_back('{32'h0, 1'b0, 1'b0});
    do_data(4'b0011, 32'h8000_0020, 32'h0000_BEEF, n1);
    chk("store_ok_after_bvalid", 32'(last_dok_cyc), 32'(b_cyc + 1));
    repeat (2) @(posedge clk); #1;

    // SLVERR read: data still delivered, bus_err sticks
    ar_q.push_back('{DATA_ID, 32'h8000_0030, 32'hCAFE_F00D, 2'b10, 1'b0, 1'b0, 2});
    data_q.push_back('{32'hCAFE_F00D, 1'b1, 1'b1});
    do_data(4'b0000, 32'h8000_0030, 32'h0, n1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("bus_err_sticky", 32'(bus_err), 32'd1);
    @(posedge clk); #1;

    // No rvalid: watchdog forces completion after 15 cycles in R
    ar_q.push_back('{INST_ID, 32'hBFC0_0008, 32'h0, 2'b00, 1'b0, 1'b1, 0});
    inst_q.push_back('{32'h0, 1'b1, 1'b1});
    do_inst(32'hBFC0_0008, n1);
    chk("timeout_latency", 32'(n1), 32'd18);
    @(negedge clk);
    chk("timeout_back_idle_rready", 32'(rready), 32'd0);
    @(posedge clk); #1;

    // Reset in the middle of AW_W
    w_q.push_back('{32'h8000_0040, 32'hDEAD_0000, 4'b1111, 8, 8, 0, 2'b00});
    data_req = 1'b1; data_wen = 4'b1111; data_addr = 32'h8000_0040; data_wdata = 32'hDEAD_0000;
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_awvalid", 32'(awvalid), 32'd1);
    chk("pre_rst_wvalid", 32'(wvalid), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_awvalid", 32'(awvalid), 32'd0);
    chk("rst_async_wvalid", 32'(wvalid), 32'd0);
    data_req = 1'b0; data_wen = '0;
    repeat (2) @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("post_rst");
    @(posedge clk); #1;

    // Fetch after reset completes cleanly
    ar_q.push_back('{INST_ID, 32'hBFC0_0100, 32'h0800_0123, 2'b00, 1'b0, 1'b0, 1});
    inst_q.push_back('{32'h0800_0123, 1'b1, 1'b0});
    do_inst(32'hBFC0_0100, n1);
    chk("post_rst_latency", 32'(n1), 32'd5);
    repeat (2) @(posedge clk); #1;

    // rid mismatch: data accepted, bus_err raised
    ar_q.push_back('{DATA_ID, 32'h8000_0050, 32'h5555_AAAA, 2'b00, 1'b1, 1'b0, 0});
    data_q.push_back('{32'h5555_AAAA, 1'b1, 1'b1});
    do_data(4'b0000, 32'h8000_0050, 32'h0, n1);
    repeat (3) @(posedge clk); #1;

    chk("inst_q_drained", 32'(inst_q.size()), 32'd0);
    chk("data_q_drained", 32'(data_q.size()), 32'd0);
    chk("ar_q_drained", 32'(ar_q.size()), 32'd0);
    chk("w_q_drained", 32'(w_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
